irq_controller: RTL
===================

// Module: irq_controller
//
// PURPOSE
//   Parametrised interrupt controller between up to 8 raw interrupt sources and the cpu core.
//   Sources are per-channel edge- or level-sensitive, maskable and fixed-priority.
//   Pending sources become one request/vector/acknowledge/end-of-interrupt handshake to the core.
//   Control registers are reached through a small memory-mapped port on the data-memory/IO bus.
//
// PARAMETERS
//   NUM_IRQ   8   number of interrupt channels, legal range 1..8
//   VEC_W     3   vector width, $clog2(NUM_IRQ) with a minimum of 1
//
// PORTS
//   clk         in   1        system clock; everything is on the rising edge
//   rst_n       in   1        synchronous reset, active low
//   irq_in      in   NUM_IRQ  raw interrupt sources (interrupt_0 at bit 0)
//   bus_addr    in   2        register select
//   bus_wdata   in   8        register write data
//   bus_we      in   1        register write strobe, one cycle
//   bus_re      in   1        register read strobe, one cycle
//   bus_rdata   out  8        read data, valid the cycle after bus_re
//   irq_req     out  1        interrupt request to the core
//   irq_vector  out  VEC_W    index of the requesting channel; stable while irq_req is high
//   irq_ack     in   1        core accepts the request (one-cycle pulse)
//   irq_eoi     in   1        core finished its service routine (one-cycle pulse)
//
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge) clears:
//     - ENABLE, MODE, PENDING, the previous-input register and bus_rdata
//     - irq_req=0, irq_vector=0, state=IDLE
//   Register map:
//     - 0 ENABLE  rw: per-channel mask
//     - 1 MODE    rw: 1=edge, 0=level
//     - 2 PENDING r; writing 1 to a bit clears it (edge channels only)
//     - 3 STATUS  r: {state[1:0], 3'b0, irq_vector}
//   Unused upper bits read 0 and ignore writes.
//   Edge channel: a 0->1 change of irq_in between consecutive edges sets PENDING[i].
//   Level channel: PENDING[i] = irq_in[i] registered every cycle.
//   Pending bit set and clear in the same cycle: set wins.
//   Eligible = PENDING & ENABLE. The lowest index has the highest priority.
//   FSM, three states:
//     - IDLE: any eligible bit -> REQ. Latch irq_vector = highest-priority eligible channel; irq_req=1 from the next cycle.
//     - REQ: irq_ack -> SERVICE, irq_req=0, and the latched edge channel's pending bit clears.
//       If the latched channel stops being eligible before the ack (masked, cleared, or level dropped) -> IDLE, irq_req=0 next cycle.
//     - SERVICE: irq_req=0, no new request; irq_eoi -> IDLE. Pending channels re-arbitrate from IDLE.
//   irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
//   A higher-priority channel arriving during REQ does not replace the latched vector.
//   Latency: irq_in edge sampled at edge k sets PENDING after edge k; irq_req is high after edge k+1.
//   Reset asserted mid-handshake aborts it: back to IDLE with irq_req=0 next cycle.
//
// CONFIGURATION
//   IRQ_SYNC_EN defined:
//     - irq_in passes through a 2-flop synchroniser per channel before edge detection
//     - adds 2 cycles of latency
//     - synchroniser flops reset to 0
//   IRQ_SYNC_EN undefined: irq_in is used directly; the sources must already be synchronous to clk.
//
// STRUCTURE
//   Package irq_pkg holds:
//     - register offsets REG_ENABLE/REG_MODE/REG_PENDING/REG_STATUS
//     - FSM state encoding, typedef irq_state_t {IDLE=0, REQ=1, SERVICE=2}
//     - MAX_IRQ=8
//   Sub-module irq_edge_detect (one per channel, generate loop):
//     - contains the optional synchroniser, the previous-value flop and the rise pulse
//   Priority encoder, registers and FSM live in the top module.
//
// TESTING
//   1. Edge path: ENABLE=0x01, MODE=0x01, pulse irq_in[0] for 1 cycle
//      -> irq_req high 2 cycles later, vector=0; ack -> PENDING=0x00; eoi -> STATUS state=IDLE.
//   2. Priority: ENABLE=0xFF, MODE=0xFF, rise irq_in[5] and irq_in[2] together
//      -> vector=2 first; after ack+eoi -> vector=5.
//   3. Masking: MODE=0x08, ENABLE=0x00, pulse irq_in[3]
//      -> PENDING=0x08, irq_req stays 0; write ENABLE=0x08 -> irq_req rises with vector=3.
//   4. Level mode: MODE=0x00, ENABLE=0x02, hold irq_in[1]=1 through ack and eoi
//      -> request re-asserts after eoi; drop irq_in[1] while in REQ -> irq_req=0 next cycle.
//   5. Corner cases: W1C to PENDING[4] in the same cycle as a new irq_in[4] rise -> PENDING[4]=1;
//      drive rst_n=0 while in SERVICE -> all registers 0, irq_req=0.
//   6. Repeat tests 1 and 3 with IRQ_SYNC_EN defined -> every latency is exactly +2 cycles.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding
// and the fixed-priority (lowest index wins) encoder.
package irq_pkg;

    localparam int MAX_IRQ = 8;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [2:0] lowest_set(input logic [MAX_IRQ-1:0] v);
        lowest_set = 3'd0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Per-channel input stage: optional 2-flop synchroniser (IRQ_SYNC_EN), previous-value
// flop and a one-cycle rise pulse. level_o is the sampled value seen by the level path.
module irq_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

`ifdef IRQ_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign level_o = sync2_q;
`else
    assign level_o = irq_i;
`endif

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_o;
        end
    end

    assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-channel edge/level pending bits, mask, fixed priority and a
// req/ack/eoi handshake FSM. Define IRQ_SYNC_EN to synchronise irq_in (+2 cycles latency).
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [1:0]         bus_addr,
    input  logic [7:0]         bus_wdata,
    input  logic               bus_we,
    input  logic               bus_re,
    output logic [7:0]         bus_rdata,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vector,
    input  logic               irq_ack,
    input  logic               irq_eoi
);

    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] level, rise, eligible, clr, vec_onehot;
    logic [MAX_IRQ-1:0] elig_ext;
    logic [VEC_W-1:0]   vec_q, vec_d, winner;
    logic [2:0]         vec_idx;
    logic [7:0]         rdata_q, rdata_d;
    logic               latched_elig;
    logic               ack_clr;
    irq_state_t         state_q, state_d;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
        irq_edge_detect u_edge (
            .clk    (clk),
            .rst_n  (rst_n),
            .irq_i  (irq_in[gi]),
            .level_o(level[gi]),
            .rise_o (rise[gi])
        );
    end

    assign eligible     = pending_q & enable_q;
    assign elig_ext     = MAX_IRQ'(eligible);
    assign winner       = VEC_W'(lowest_set(elig_ext));
    assign vec_idx      = 3'(vec_q);
    assign latched_elig = elig_ext[vec_idx];
    assign vec_onehot   = NUM_IRQ'(1) << vec_q;

    // An ack is honoured even if the latched channel drops eligibility in the same cycle.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ack_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    vec_d   = winner;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                    ack_clr = 1'b1;
                end else if (!latched_elig) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge channels: a new rise beats any clear; level channels just follow the input.
    always_comb begin
        clr       = ((bus_we && bus_addr == REG_PENDING) ? bus_wdata[NUM_IRQ-1:0] : '0)
                  | (ack_clr ? vec_onehot : '0);
        pending_d = (mode_q & (rise | (pending_q & ~clr))) | (~mode_q & level);
        enable_d  = (bus_we && bus_addr == REG_ENABLE) ? bus_wdata[NUM_IRQ-1:0] : enable_q;
        mode_d    = (bus_we && bus_addr == REG_MODE)   ? bus_wdata[NUM_IRQ-1:0] : mode_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus_re) begin
            case (bus_addr)
                REG_ENABLE:  rdata_d = 8'(enable_q);
                REG_MODE:    rdata_d = 8'(mode_q);
                REG_PENDING: rdata_d = 8'(pending_q);
                default:     rdata_d = {state_q, 6'(vec_q)};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            vec_q     <= '0;
            rdata_q   <= '0;
            state_q   <= IDLE;
        end else begin
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            rdata_q   <= rdata_d;
            state_q   <= state_d;
        end
    end

    assign irq_req    = (state_q == REQ);
    assign irq_vector = vec_q;
    assign bus_rdata  = rdata_q;

endmodule
